// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: serialises scancodes as 11-bit frames on the PS/2 lines.
// Optional break-prefix support (0xF0 before the byte) is enabled with `define PS2_TX_BREAK_EN.
module ps2_device_tx #(
    parameter int unsigned HALF_CYCLES = 4000,
    parameter int unsigned GAP_CYCLES  = 8000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_break,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_abort,
    input  logic       ps2_clk_in,
    output logic       ps2_clk_o,
    output logic       ps2_data_o
);

    localparam int unsigned CNT_MAX = (HALF_CYCLES > GAP_CYCLES) ? HALF_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StBitHi, StBitLo, StGap, StWaitInh} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [10:0]      frame_q, frame_d;
    logic [7:0]       pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             inh_q, inh_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic             accept;

`ifndef PS2_TX_BREAK_EN
    logic unused_break;
    assign unused_break = tx_break;
`endif

    function automatic logic [10:0] make_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    // Ready is withheld during the done pulse so the next accept lands one cycle later.
    assign tx_ready = (state_q == StIdle) & ps2_clk_in & ~done_q & ~rst;
    assign accept   = tx_valid & tx_ready;
    assign tx_done  = done_q;
    assign tx_abort = abort_q;

    assign ps2_clk_o  = (state_q != StBitLo);
    assign ps2_data_o = (state_q == StBitHi || state_q == StBitLo) ? frame_q[bit_idx_q] : 1'b1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        frame_d      = frame_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        inh_d        = inh_q;
        done_d       = 1'b0;
        abort_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d     = '0;
                    bit_idx_d = 4'd0;
                    inh_d     = 1'b0;
                    frame_d   = make_frame(tx_data);
                    state_d   = StBitHi;
`ifdef PS2_TX_BREAK_EN
                    if (tx_break) begin
                        frame_d      = make_frame(8'hF0);
                        pend_d       = tx_data;
                        pend_valid_d = 1'b1;
                    end
`endif
                end
            end
            StBitHi: begin
                // First cycle of the phase is ignored: the line may still be settling high.
                if (cnt_q != '0 && !ps2_clk_in && inh_q) begin
                    state_d   = StWaitInh;
                    cnt_d     = '0;
                    bit_idx_d = 4'd0;
                    inh_d     = 1'b0;
                    abort_d   = 1'b1;
                end else begin
                    inh_d = (cnt_q != '0) && !ps2_clk_in;
                    if (cnt_q == HALF_LAST) begin
                        cnt_d   = '0;
                        inh_d   = 1'b0;
                        state_d = StBitLo;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StBitLo: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q == 4'd10) begin
                        state_d = StGap;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        state_d   = StBitHi;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (pend_valid_q) begin
                        frame_d      = make_frame(pend_q);
                        pend_valid_d = 1'b0;
                        bit_idx_d    = 4'd0;
                        state_d      = StBitHi;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitInh: begin
                // Host must release the clock for a full gap before the byte is resent.
                if (!ps2_clk_in) begin
                    cnt_d = '0;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = 4'd0;
                    state_d   = StBitHi;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_idx_q    <= 4'd0;
            frame_q      <= 11'h7FF;
            pend_q       <= 8'h00;
            pend_valid_q <= 1'b0;
            inh_q        <= 1'b0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            frame_q      <= frame_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            inh_q        <= inh_d;
            done_q       <= done_d;
            abort_q      <= abort_d;
        end
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx with HALF_CYCLES=4, GAP_CYCLES=16.
// Honours PS2_TX_BREAK_EN the same way as the design.
module tb_ps2_device_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_break = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_abort;
    logic       ps2_clk_in = 1'b1;
    logic       ps2_clk_o, ps2_data_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int nbits = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    logic [255:0] cap = '0;

    localparam logic [10:0] FRAME_16 = 11'h42C;
    localparam logic [10:0] FRAME_4E = 11'h69C;
    localparam logic [10:0] FRAME_F0 = 11'h7E0;

    ps2_device_tx #(
        .HALF_CYCLES(4),
        .GAP_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_break  (tx_break),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_done   (tx_done),
        .tx_abort  (tx_abort),
        .ps2_clk_in(ps2_clk_in),
        .ps2_clk_o (ps2_clk_o),
        .ps2_data_o(ps2_data_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Host model: sample data on the falling edge of the device clock.
    always @(negedge ps2_clk_o) begin
        cap[nbits] <= ps2_data_o;
        nbits      <= nbits + 1;
    end

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tx_abort === 1'b1) abort_cnt <= abort_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic brk, output int acc_cyc);
        @(negedge clk);
        check_eq("ready_before_accept", 32'(tx_ready), 32'd1);
        tx_data  = b;
        tx_break = brk;
        tx_valid = 1'b1;
        acc_cyc  = cyc;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_break = 1'b0;
        check_eq("ready_after_accept", 32'(tx_ready), 32'd0);
    endtask

    task automatic wait_done(input int max_cyc, output int done_cyc);
        bit found = 0;
        done_cyc = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (tx_done === 1'b1) begin
                found    = 1;
                done_cyc = cyc;
                check_eq("ready_in_done_cycle", 32'(tx_ready), 32'd0);
                break;
            end
        end
        if (!found) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int acc, dcyc, base, d0, a0, rel;
        bit seen;

        // Reset
        idle(2);
        check_eq("rst_ready", 32'(tx_ready), 32'd0);
        check_eq("rst_clk_o", 32'(ps2_clk_o), 32'd1);
        check_eq("rst_data_o", 32'(ps2_data_o), 32'd1);
        check_eq("rst_done", 32'(tx_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", 32'(tx_ready), 32'd1);

        // 1: single byte 0x16
        base = nbits;
        d0   = done_cnt;
        send(8'h16, 1'b0, acc);
        wait_done(300, dcyc);
        check_eq("s1_latency", 32'(dcyc - acc), 32'd105);
        check_eq("s1_nbits", 32'(nbits - base), 32'd11);
        check_eq("s1_frame", 32'(cap[base +: 11]), 32'(FRAME_16));
        @(negedge clk);
        check_eq("s1_ready_after_done", 32'(tx_ready), 32'd1);
        check_eq("s1_done_count", 32'(done_cnt - d0), 32'd1);
        check_eq("s1_no_abort", 32'(abort_cnt), 32'd0);

        // 2: 0x4E then 0x16 back to back
        base = nbits;
        send(8'h4E, 1'b0, acc);
        wait_done(300, dcyc);
        check_eq("s2a_latency", 32'(dcyc - acc), 32'd105);
        send(8'h16, 1'b0, acc);
        check_eq("s2_b2b_accept", 32'(acc - dcyc), 32'd1);
        wait_done(300, dcyc);
        check_eq("s2b_latency", 32'(dcyc - acc), 32'd105);
        check_eq("s2_nbits", 32'(nbits - base), 32'd22);
        check_eq("s2_frame_4e", 32'(cap[base +: 11]), 32'(FRAME_4E));
        check_eq("s2_frame_16", 32'(cap[base + 11 +: 11]), 32'(FRAME_16));

        // 3: inhibit in idle
        idle(3);
        ps2_clk_in = 1'b0;
        idle(2);
        check_eq("s3_ready_inhibit", 32'(tx_ready), 32'd0);
        base = nbits;
        d0   = done_cnt;
        tx_data  = 8'h16;
        tx_valid = 1'b1;
        idle(5);
        tx_valid = 1'b0;
        idle(20);
        check_eq("s3_no_bits", 32'(nbits - base), 32'd0);
        check_eq("s3_clk_high", 32'(ps2_clk_o), 32'd1);
        check_eq("s3_data_high", 32'(ps2_data_o), 32'd1);
        check_eq("s3_no_done", 32'(done_cnt - d0), 32'd0);
        ps2_clk_in = 1'b1;
        @(negedge clk);
        check_eq("s3_ready_release", 32'(tx_ready), 32'd1);

        // 4: host inhibits during bit 5 high phase
        base = nbits;
        d0   = done_cnt;
        a0   = abort_cnt;
        send(8'h16, 1'b0, acc);
        for (int i = 0; i < 200 && (nbits - base) < 5; i++) @(negedge clk);
        check_eq("s4_reached_bit5", 32'(nbits - base), 32'd5);
        for (int i = 0; i < 20 && ps2_clk_o !== 1'b1; i++) @(negedge clk);
        ps2_clk_in = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_abort === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check_eq("s4_abort_pulse", 32'(seen), 32'd1);
        check_eq("s4_clk_released", 32'(ps2_clk_o), 32'd1);
        check_eq("s4_data_released", 32'(ps2_data_o), 32'd1);
        idle(8);
        check_eq("s4_ready_while_inh", 32'(tx_ready), 32'd0);
        check_eq("s4_data_hold", 32'(ps2_data_o), 32'd1);
        ps2_clk_in = 1'b1;
        rel  = cyc;
        base = nbits;
        wait_done(300, dcyc);
        check_eq("s4_resend_latency", 32'(dcyc - rel), 32'd120);
        check_eq("s4_nbits", 32'(nbits - base), 32'd11);
        check_eq("s4_frame", 32'(cap[base +: 11]), 32'(FRAME_16));
        idle(2);
        check_eq("s4_abort_count", 32'(abort_cnt - a0), 32'd1);
        check_eq("s4_done_count", 32'(done_cnt - d0), 32'd1);

        // 5: break prefix request
        base = nbits;
        d0   = done_cnt;
        send(8'h16, 1'b1, acc);
        wait_done(400, dcyc);
`ifdef PS2_TX_BREAK_EN
        check_eq("s5_latency", 32'(dcyc - acc), 32'd209);
        check_eq("s5_nbits", 32'(nbits - base), 32'd22);
        check_eq("s5_frame_f0", 32'(cap[base +: 11]), 32'(FRAME_F0));
        check_eq("s5_frame_16", 32'(cap[base + 11 +: 11]), 32'(FRAME_16));
`else
        check_eq("s5_latency", 32'(dcyc - acc), 32'd105);
        check_eq("s5_nbits", 32'(nbits - base), 32'd11);
        check_eq("s5_frame_16", 32'(cap[base +: 11]), 32'(FRAME_16));
`endif
        idle(30);
        check_eq("s5_done_count", 32'(done_cnt - d0), 32'd1);

        // 6: reset mid-frame
        send(8'h16, 1'b0, acc);
        idle(30);
        rst = 1'b1;
        @(negedge clk);
        check_eq("s6_clk_o", 32'(ps2_clk_o), 32'd1);
        check_eq("s6_data_o", 32'(ps2_data_o), 32'd1);
        check_eq("s6_ready_in_rst", 32'(tx_ready), 32'd0);
        rst = 1'b0;
        d0  = done_cnt;
        a0  = abort_cnt;
        idle(150);
        check_eq("s6_no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("s6_no_abort", 32'(abort_cnt - a0), 32'd0);
        check_eq("s6_ready_after", 32'(tx_ready), 32'd1);
        check_eq("s6_clk_idle", 32'(ps2_clk_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
